// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver: state encoding,
// active-high glyph table and output off-pattern helpers.
package seg7_pkg;

   localparam logic BLANK = 1'b0;
   localparam logic SHOW  = 1'b1;

   // Glyphs are active-high {g,f,e,d,c,b,a}
   localparam logic [6:0] GLYPH_0 = 7'h3F;
   localparam logic [6:0] GLYPH_1 = 7'h06;
   localparam logic [6:0] GLYPH_2 = 7'h5B;
   localparam logic [6:0] GLYPH_3 = 7'h4F;
   localparam logic [6:0] GLYPH_4 = 7'h66;
   localparam logic [6:0] GLYPH_5 = 7'h6D;
   localparam logic [6:0] GLYPH_6 = 7'h7D;
   localparam logic [6:0] GLYPH_7 = 7'h07;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h6F;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h7C;
   localparam logic [6:0] GLYPH_C = 7'h39;
   localparam logic [6:0] GLYPH_D = 7'h5E;
   localparam logic [6:0] GLYPH_E = 7'h79;
   localparam logic [6:0] GLYPH_F = 7'h71;

   localparam logic [7:0] SEG_OFF_AH = 8'h00;
   localparam logic [3:0] DIG_OFF_AH = 4'h0;

   function automatic logic [7:0] seg_drive(input logic [7:0] seg_ah, input logic act_low);
      return act_low ? ~seg_ah : seg_ah;
   endfunction

   function automatic logic [3:0] dig_drive(input logic [3:0] dig_ah, input logic act_low);
      return act_low ? ~dig_ah : dig_ah;
   endfunction

endpackage

// File: rtl/seg7_scan_module_if.sv
// Display bus between the BCD counter side (master) and the scan driver (slave).
interface seg7_scan_module_if;

   logic [15:0] Number_Sig;
   logic [3:0]  DP_Sig;
   logic        LZB_En;
   logic [7:0]  SMG_Data;
   logic [3:0]  Scan_Sig;

   modport master (
      output Number_Sig,
      output DP_Sig,
      output LZB_En,
      input  SMG_Data,
      input  Scan_Sig
   );

   modport slave (
      input  Number_Sig,
      input  DP_Sig,
      input  LZB_En,
      output SMG_Data,
      output Scan_Sig
   );

endinterface

// File: rtl/seg7_glyph_decoder.sv
// Combinational nibble-to-glyph decoder; 10..15 render as hex so bad BCD is visible.
module seg7_glyph_decoder
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH_0;
      case (nibble)
         4'h0: glyph = GLYPH_0;
         4'h1: glyph = GLYPH_1;
         4'h2: glyph = GLYPH_2;
         4'h3: glyph = GLYPH_3;
         4'h4: glyph = GLYPH_4;
         4'h5: glyph = GLYPH_5;
         4'h6: glyph = GLYPH_6;
         4'h7: glyph = GLYPH_7;
         4'h8: glyph = GLYPH_8;
         4'h9: glyph = GLYPH_9;
         4'hA: glyph = GLYPH_A;
         4'hB: glyph = GLYPH_B;
         4'hC: glyph = GLYPH_C;
         4'hD: glyph = GLYPH_D;
         4'hE: glyph = GLYPH_E;
         4'hF: glyph = GLYPH_F;
         default: glyph = GLYPH_0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_module.sv
// Four-digit multiplexed 7-segment scan driver with per-frame snapshot,
// ghost-suppression blank slots, leading-zero blanking and decimal points.
//
//   state | meaning
//   BLANK | all digits and segments off before showing digit idx
//   SHOW  | digit idx enabled, segments = glyph of snapshot nibble idx
module seg7_scan_module
   import seg7_pkg::*;
#(
   parameter logic [22:0] T_SCAN      = 23'd49_999,
   parameter logic [22:0] T_BLANK     = 23'd499,
   parameter bit          SEG_ACT_LOW = 1'b1,
   parameter bit          DIG_ACT_LOW = 1'b1
) (
   input logic               CLK,
   input logic               RST,
   seg7_scan_module_if.slave bus
);

   logic        state;
   logic        state_nxt;
   logic [22:0] cnt;
   logic [1:0]  idx;
   logic [15:0] snap;
   logic [3:0]  dp_snap;
   logic        lzb_q;

   logic [3:0]  nib;
   logic [6:0]  glyph;
   logic [3:0]  lz_blank;
   logic [7:0]  seg_nxt;
   logic [3:0]  scan_nxt;

   seg7_glyph_decoder u_glyph (
      .nibble (nib),
      .glyph  (glyph)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= BLANK;
         cnt          <= '0;
         idx          <= '0;
         snap         <= '0;
         dp_snap      <= '0;
         lzb_q        <= 1'b0;
         bus.SMG_Data <= seg_drive(SEG_OFF_AH, SEG_ACT_LOW);
         bus.Scan_Sig <= dig_drive(DIG_OFF_AH, DIG_ACT_LOW);
      end else begin
         state <= state_nxt;
         cnt   <= (state_nxt != state) ? 23'd0 : cnt + 23'd1;
         if (state == SHOW && state_nxt == BLANK)
            idx <= idx + 2'd1;
         // One snapshot per frame keeps all four digits consistent
         if (state == BLANK && idx == 2'd0 && cnt == 23'd0) begin
            snap    <= bus.Number_Sig;
            dp_snap <= bus.DP_Sig;
            lzb_q   <= bus.LZB_En;
         end
         bus.SMG_Data <= seg_drive(seg_nxt, SEG_ACT_LOW);
         bus.Scan_Sig <= dig_drive(scan_nxt, DIG_ACT_LOW);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         BLANK:   if (cnt == T_BLANK) state_nxt = SHOW;
         SHOW:    if (cnt == T_SCAN)  state_nxt = BLANK;
         default: state_nxt = BLANK;
      endcase
   end

   // A digit blanks only when it and every digit to its left are zero
   always_comb begin
      lz_blank    = 4'b0000;
      lz_blank[3] = lzb_q && (snap[15:12] == 4'h0);
      lz_blank[2] = lz_blank[3] && (snap[11:8] == 4'h0);
      lz_blank[1] = lz_blank[2] && (snap[7:4] == 4'h0);
   end

   always_comb begin
      nib      = snap[{idx, 2'b00} +: 4];
      seg_nxt  = SEG_OFF_AH;
      scan_nxt = DIG_OFF_AH;
      if (state_nxt == SHOW) begin
         scan_nxt = 4'b0001 << idx;
         seg_nxt  = {dp_snap[idx], lz_blank[idx] ? 7'h00 : glyph};
      end
   end

endmodule

// File: tb/tb_seg7_scan_module.sv
// Directed, table-driven bench for seg7_scan_module with short slots (6-clock digit, 24-clock frame).
module tb_seg7_scan_module;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   seg7_scan_module_if bus ();

   seg7_scan_module #(
      .T_SCAN      (23'd3),
      .T_BLANK     (23'd1),
      .SEG_ACT_LOW (1'b1),
      .DIG_ACT_LOW (1'b1)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0]      num;
      logic [3:0]       dp;
      logic             lzb;
      logic [3:0][7:0]  seg;
      string            name;
   } vec_t;

   int passed = 0;
   int total  = 0;
   logic [3:0] scan_on [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   vec_t vecs [8];
   vec_t v_tear1, v_tear2, v_pre, v_post;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Runs n_cyc clocks of a frame starting in clock 1 of BLANK(0), checking every cycle
   task automatic run_frame(input vec_t v, input int n_cyc, input int chg_at, input logic [15:0] chg_num);
      int d;
      int p;
      bus.Number_Sig = v.num;
      bus.DP_Sig     = v.dp;
      bus.LZB_En     = v.lzb;
      for (int c = 0; c < n_cyc; c++) begin
         d = c / 6;
         p = c % 6;
         if (c == chg_at) bus.Number_Sig = chg_num;
         @(negedge clk);
         if (p < 2) begin
            check($sformatf("%s c%0d seg blank", v.name, c), bus.SMG_Data, 8'hFF);
            check($sformatf("%s c%0d scan blank", v.name, c), {4'h0, bus.Scan_Sig}, 8'h0F);
         end else begin
            check($sformatf("%s c%0d seg d%0d", v.name, c, d), bus.SMG_Data, v.seg[d]);
            check($sformatf("%s c%0d scan d%0d", v.name, c, d), {4'h0, bus.Scan_Sig}, {4'h0, scan_on[d]});
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // seg fields listed digit3..digit0
      vecs[0] = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, "static1234"};
      vecs[1] = '{16'h0007, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hF8}, "lzb_on"};
      vecs[2] = '{16'h0007, 4'b0000, 1'b0, {8'hC0, 8'hC0, 8'hC0, 8'hF8}, "lzb_off"};
      vecs[3] = '{16'hFA00, 4'b0100, 1'b0, {8'h8E, 8'h08, 8'hC0, 8'hC0}, "hex_dp"};
      vecs[4] = '{16'h0050, 4'b1000, 1'b1, {8'h7F, 8'hFF, 8'h92, 8'hC0}, "lzb_dp"};
      vecs[5] = '{16'h0000, 4'b0000, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hC0}, "lzb_zero"};
      vecs[6] = '{16'hBCDE, 4'b0001, 1'b0, {8'h83, 8'hC6, 8'hA1, 8'h06}, "hex_bcde"};
      vecs[7] = '{16'h5068, 4'b0000, 1'b1, {8'h92, 8'hC0, 8'h82, 8'h80}, "lzb_inner0"};
      v_tear1 = '{16'h1111, 4'b0000, 1'b0, {8'hF9, 8'hF9, 8'hF9, 8'hF9}, "tear_f1"};
      v_tear2 = '{16'h2222, 4'b0000, 1'b0, {8'hA4, 8'hA4, 8'hA4, 8'hA4}, "tear_f2"};
      v_pre   = '{16'h1234, 4'b0000, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99}, "pre_rst"};
      v_post  = '{16'h4321, 4'b0000, 1'b0, {8'h99, 8'hB0, 8'hA4, 8'hF9}, "post_rst"};

      bus.Number_Sig = 16'h0000;
      bus.DP_Sig     = 4'b0000;
      bus.LZB_En     = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset seg", bus.SMG_Data, 8'hFF);
      check("reset scan", {4'h0, bus.Scan_Sig}, 8'h0F);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < 8; i++) run_frame(vecs[i], 24, -1, 16'h0000);

      run_frame(v_tear1, 24, 9, 16'h2222);
      run_frame(v_tear2, 24, -1, 16'h0000);

      // Reset lands in digit 2 SHOW slot
      run_frame(v_pre, 15, -1, 16'h0000);
      rst = 1'b1;
      bus.Number_Sig = 16'h4321;
      @(posedge clk);
      #1 rst = 1'b0;
      run_frame(v_post, 24, -1, 16'h0000);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/seg7_scan_module.md
# seg7_scan_module

Four-digit multiplexed 7-segment scan driver. It is the display-side consumer of the 16-bit, four-nibble `Number_Sig` bus produced by the BCD counter. It snapshots the value once per frame and time-multiplexes the digits onto one shared segment bus, with a ghost-suppression blank slot before each digit. It also provides optional leading-zero blanking and per-digit decimal points.

## Interface
- `T_SCAN`, default 23'd49_999: SHOW slot length minus 1, in clocks (1 ms at 50 MHz).
- `T_BLANK`, default 23'd499: BLANK slot length minus 1, in clocks (10 µs at 50 MHz).
- `SEG_ACT_LOW`, default 1: 1 means segment lines are active-low.
- `DIG_ACT_LOW`, default 1: 1 means digit enables are active-low.
- `CLK` input, 1 bit: single system clock; all logic on rising edge.
- `RST` input, 1 bit: reset, synchronous and active-high.
- `Number_Sig` input, 16 bits: 4 nibbles; `[3:0]` is the rightmost digit (digit 0), `[15:12]` is digit 3.
- `DP_Sig` input, 4 bits: decimal point request per digit; bit n maps to digit n.
- `LZB_En` input, 1 bit: leading-zero blanking enable.
- `SMG_Data` output, 8 bits: `{dp,g,f,e,d,c,b,a}`, registered.
- `Scan_Sig` output, 4 bits: digit enables; bit n maps to digit n, one-hot when active, registered.

## Operation
- **FSM states:** BLANK and SHOW.
- **Digit index:** `idx` is 2 bits. Slot counter `cnt` is 23 bits.
- **Slot sequence:** BLANK(idx) → SHOW(idx) → BLANK(idx+1). `idx` wraps 3 → 0.
- **BLANK slot:** lasts T_BLANK+1 clocks.
  - All digits off.
  - All segments off, including dp.
- **SHOW slot:** lasts T_SCAN+1 clocks.
  - Only digit `idx` is on.
  - `SMG_Data` = glyph(snap nibble idx) plus dp = `DP_Sig[idx]`.
- **Counter rule:** `cnt` resets to 0 on every state change. The state changes when `cnt` equals the slot's terminal value.
- **Frame snapshot:**
  - `snap` (16 bits) and `dp_snap` (4 bits) load `Number_Sig` and `DP_Sig` on the clock where state = BLANK, idx = 0 and cnt = 0.
  - All four digits of a frame come from one snapshot, so there is no tearing.
- **Glyphs:**
  - Nibbles 0–9 map to decimal glyphs.
  - Nibbles 10–15 map to hex glyphs A, b, C, d, E, F. Out-of-range BCD therefore stays visible for debug.
- **Leading-zero blanking (LZB):**
  - Applies when `LZB_En` was 1 at the snapshot; latch it with the snapshot.
  - Digit n (n = 3..1) shows no segments if its nibble and all higher nibbles are 0. dp is still driven.
  - Digit 0 is never blanked.
- **Polarity:** applied at the output register only. "Off" means all 1s when active-low and all 0s when active-high.

## Timing
- **Reset values:**
  - state = BLANK, idx = 0, cnt = 0, snap = 0, dp_snap = 0, LZB latch = 0.
  - `SMG_Data` = off (8'hFF when SEG_ACT_LOW = 1).
  - `Scan_Sig` = off (4'hF when DIG_ACT_LOW = 1).
- **First edge after RST deasserts:** captures the snapshot.
- **Output latency:** outputs are registered from next-state. `Scan_Sig` and `SMG_Data` change on the same edge as the state change; there is no extra cycle of skew between them.
- **Frame period:** 4 × (T_BLANK + T_SCAN + 2) clocks. Snapshot period is equal to the frame period.
- **Input changes:** a change in `Number_Sig` mid-frame is not shown until the next frame. Worst-case display latency is one frame plus one clock.
- **Snapshot coincidence:** if `Number_Sig` changes on the same edge as the snapshot, the pre-edge value is captured.
- **RST mid-slot:** outputs go off on that edge, the FSM restarts at BLANK, idx 0.
- **Enable exclusivity:** digit enables are never active during BLANK. No two enables are ever active at once.

## Structure
- **Package `seg7_pkg`:**
  - Glyph constants for 0–F (active-high `{g..a}` form).
  - State encoding localparams BLANK and SHOW.
  - Off-pattern helper constants.
- **Sub-module `seg7_glyph_decoder`:** combinational, 4-bit nibble in, 7-bit active-high glyph out.
- **Top module:** FSM, counter, snapshot, LZB, polarity and output registers.

## Test plan
Bench uses T_SCAN = 3 and T_BLANK = 1, so a digit slot is 6 clocks and a frame is 24 clocks.
- **Reset:** hold RST for 3 clocks, release → `SMG_Data` = 8'hFF and `Scan_Sig` = 4'hF through the first 2 clocks; `Scan_Sig` = 4'b1110 on clocks 3–6.
- **Static value:** `Number_Sig` = 16'h1234, `DP_Sig` = 0, `LZB_En` = 0 → per frame digits 0..3 show 4, 3, 2, 1. Active-low glyphs are 8'h99, 8'hB0, 8'hA4, 8'hF9. Each is on for 4 clocks and followed by a 2-clock all-off gap.
- **LZB:** `Number_Sig` = 16'h0007, `LZB_En` = 1 → digit 0 shows 8'hF8; digits 1–3 show 8'hFF while their enables pulse. With `LZB_En` = 0, digits 1–3 show 8'hC0.
- **Tearing:** change `Number_Sig` from 16'h1111 to 16'h2222 during the SHOW slot of digit 1 → digits 2 and 3 of that frame still show 1. The next frame shows all 2s.
- **Hex and dp:** `Number_Sig` = 16'hFA00, `DP_Sig` = 4'b0100 → digit 3 shows F (8'h8E), digit 2 shows A with dp (8'h08).
- **Reset mid-SHOW:** assert RST for 1 clock during digit 2's SHOW slot → outputs off on the next edge; the sequence restarts at BLANK(0); a new snapshot is taken.
